// File: rtl/prom_coherente_ctrl.sv
// Sequencer for the coherent-averaging datapath: config latch, averager clear, trigger alignment,
// stream gating and output counting. Optional watchdog enabled with `define PROM_CTRL_TIMEOUT_EN.
module prom_coherente_ctrl #(
    parameter int BUF_TAM        = 2048,
    parameter int CNT_W          = 32,
    parameter int TIMEOUT_CYCLES = 65536
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [15:0]      cfg_ptos_x_ciclo,
    input  logic [15:0]      cfg_frames,
    input  logic [15:0]      cfg_bloques,
    input  logic             frame_sync,
    input  logic             data_in_valid,
    input  logic [31:0]      data_in,
    output logic             avg_rst_n,
    output logic             avg_enable,
    output logic [15:0]      avg_ptos_x_ciclo,
    output logic [15:0]      avg_frames,
    output logic             avg_data_valid,
    output logic [31:0]      avg_data,
    input  logic             avg_out_valid,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [CNT_W-1:0] muestras_out
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_ARM,
        S_RUN,
        S_DONE
    } state_t;

    localparam int CLR_W = $clog2(BUF_TAM + 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CLR_W-1:0]   r_clr_cnt;
    logic [15:0]        r_ptos;
    logic [15:0]        r_frames;
    logic [15:0]        r_bloques;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_error;
    logic               r_avg_rst_n;
    logic               r_avg_enable;
    logic               r_avg_data_valid;
    logic [31:0]        r_avg_data;
    logic               r_busy;
    logic               r_done;

    logic               w_start_ok;
    logic               w_cfg_bad;
    logic               w_trigger;
    logic [31:0]        w_prod;
    logic [CNT_W-1:0]   w_target;
    logic               w_last_out;
    logic               w_timeout;
    logic               w_fwd;

    assign w_start_ok = start && (r_state == S_IDLE || r_state == S_DONE);
    assign w_cfg_bad  = (cfg_ptos_x_ciclo == '0) || (32'(cfg_ptos_x_ciclo) > BUF_TAM)
                     || (cfg_frames == '0) || (cfg_bloques == '0);
    assign w_trigger  = data_in_valid && frame_sync;

    // Completion target is M*R, formed at full width before fitting it to the counter.
    assign w_prod     = {16'd0, r_ptos} * {16'd0, r_bloques};
    assign w_target   = CNT_W'(w_prod);
    assign w_last_out = (r_state == S_RUN) && avg_out_valid && (r_cnt + CNT_W'(1) == w_target);

`ifdef PROM_CTRL_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WD_W-1:0] r_wd;
    logic            w_waiting;

    assign w_waiting = (r_state == S_ARM || r_state == S_RUN) && !data_in_valid;
    assign w_timeout = w_waiting && (r_wd == WD_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wd <= '0;
        end else if (w_waiting) begin
            r_wd <= r_wd + WD_W'(1);
        end else begin
            r_wd <= '0;
        end
    end
`else
    // Watchdog absent: this comparison is constant false for any legal limit.
    assign w_timeout = (TIMEOUT_CYCLES < 0);
`endif

    // NOTE: every path of a combinational block must assign its outputs; the default
    // on the first line keeps the next-state logic free of inferred latches.
    always_comb begin
        w_state_nxt = r_state;
        if (abort) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        w_state_nxt = w_cfg_bad ? S_IDLE : S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    if (r_clr_cnt == CLR_W'(BUF_TAM)) begin
                        w_state_nxt = S_ARM;
                    end
                end
                S_ARM: begin
                    if (w_timeout) begin
                        w_state_nxt = S_IDLE;
                    end else if (w_trigger) begin
                        w_state_nxt = S_RUN;
                    end
                end
                S_RUN: begin
                    if (w_last_out) begin
                        w_state_nxt = S_DONE;
                    end else if (w_timeout) begin
                        w_state_nxt = S_IDLE;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // The trigger sample is forwarded on the ARM->RUN edge; leaving RUN stops forwarding at once.
    assign w_fwd = (w_state_nxt == S_RUN) && data_in_valid;

    // NOTE: state is updated with non-blocking assignments so every register samples
    // the pre-edge values, independent of statement order inside the block.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state          <= S_IDLE;
            r_clr_cnt        <= '0;
            r_ptos           <= '0;
            r_frames         <= '0;
            r_bloques        <= '0;
            r_cnt            <= '0;
            r_error          <= 1'b0;
            r_avg_rst_n      <= 1'b0;
            r_avg_enable     <= 1'b0;
            r_avg_data_valid <= 1'b0;
            r_avg_data       <= '0;
            r_busy           <= 1'b0;
            r_done           <= 1'b0;
        end else begin
            r_state          <= w_state_nxt;
            r_clr_cnt        <= (r_state == S_CLEAR) ? r_clr_cnt + CLR_W'(1) : '0;
            // Averager reset pulses low only on the first CLEAR cycle.
            r_avg_rst_n      <= !(w_state_nxt == S_CLEAR && r_state != S_CLEAR);
            r_avg_enable     <= (w_state_nxt == S_ARM) || (w_state_nxt == S_RUN);
            r_busy           <= (w_state_nxt == S_CLEAR) || (w_state_nxt == S_ARM)
                             || (w_state_nxt == S_RUN);
            r_done           <= (w_state_nxt == S_DONE);
            r_avg_data_valid <= w_fwd;
            if (w_fwd) begin
                r_avg_data <= data_in;
            end

            if (!abort) begin
                if (w_start_ok) begin
                    r_ptos    <= cfg_ptos_x_ciclo;
                    r_frames  <= cfg_frames;
                    r_bloques <= cfg_bloques;
                    r_cnt     <= '0;
                    r_error   <= w_cfg_bad;
                end else begin
                    if (r_state == S_RUN && avg_out_valid) begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                    if (w_timeout && !w_last_out) begin
                        r_error <= 1'b1;
                    end
                end
            end
        end
    end

    assign avg_rst_n        = r_avg_rst_n;
    assign avg_enable       = r_avg_enable;
    assign avg_ptos_x_ciclo = r_ptos;
    assign avg_frames       = r_frames;
    assign avg_data_valid   = r_avg_data_valid;
    assign avg_data         = r_avg_data;
    assign busy             = r_busy;
    assign done             = r_done;
    assign error            = r_error;
    assign muestras_out     = r_cnt;

endmodule

// File: tb/tb_prom_coherente_ctrl.sv
// Directed bench for prom_coherente_ctrl: reset, full acquisition, config errors, abort,
// ignored start pulses and the no-watchdog wait.
module tb_prom_coherente_ctrl;

    localparam int BUF_TAM = 2048;
    localparam int CNT_W   = 32;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic             abort;
    logic [15:0]      cfg_ptos_x_ciclo;
    logic [15:0]      cfg_frames;
    logic [15:0]      cfg_bloques;
    logic             frame_sync;
    logic             data_in_valid;
    logic [31:0]      data_in;
    logic             avg_rst_n;
    logic             avg_enable;
    logic [15:0]      avg_ptos_x_ciclo;
    logic [15:0]      avg_frames;
    logic             avg_data_valid;
    logic [31:0]      avg_data;
    logic             avg_out_valid;
    logic             busy;
    logic             done;
    logic             error;
    logic [CNT_W-1:0] muestras_out;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    prom_coherente_ctrl #(
        .BUF_TAM(BUF_TAM),
        .CNT_W  (CNT_W)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .abort           (abort),
        .cfg_ptos_x_ciclo(cfg_ptos_x_ciclo),
        .cfg_frames      (cfg_frames),
        .cfg_bloques     (cfg_bloques),
        .frame_sync      (frame_sync),
        .data_in_valid   (data_in_valid),
        .data_in         (data_in),
        .avg_rst_n       (avg_rst_n),
        .avg_enable      (avg_enable),
        .avg_ptos_x_ciclo(avg_ptos_x_ciclo),
        .avg_frames      (avg_frames),
        .avg_data_valid  (avg_data_valid),
        .avg_data        (avg_data),
        .avg_out_valid   (avg_out_valid),
        .busy            (busy),
        .done            (done),
        .error           (error),
        .muestras_out    (muestras_out)
    );

    // Outputs are sampled 1 ns after the rising edge; inputs change there too.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [15:0] m, input logic [15:0] n, input logic [15:0] r);
        cfg_ptos_x_ciclo = m;
        cfg_frames       = n;
        cfg_bloques      = r;
        start            = 1'b1;
        step();
        start            = 1'b0;
    endtask

    task automatic go_to_run(input logic [15:0] m, input logic [15:0] n, input logic [15:0] r);
        do_start(m, n, r);
        data_in_valid = 1'b0;
        frame_sync    = 1'b0;
        repeat (BUF_TAM + 1) step();
        data_in_valid = 1'b1;
        frame_sync    = 1'b1;
        data_in       = 32'h1000;
        step();
        frame_sync    = 1'b0;
        data_in_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; abort = 1'b0; frame_sync = 1'b0; data_in_valid = 1'b0;
        data_in = '0; avg_out_valid = 1'b0;
        cfg_ptos_x_ciclo = 16'd8; cfg_frames = 16'd4; cfg_bloques = 16'd2;
        step(); step();
        checks++; if (avg_rst_n !== 1'b0) begin errors++; $display("FAIL reset_avg_rst_n: got %b want 0", avg_rst_n); end
        checks++; if (avg_enable !== 1'b0) begin errors++; $display("FAIL reset_avg_enable: got %b want 0", avg_enable); end
        checks++; if (avg_data_valid !== 1'b0 || avg_data !== 32'd0) begin errors++; $display("FAIL reset_avg_data: got %b/%0h want 0/0", avg_data_valid, avg_data); end
        checks++; if ({busy, done, error} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b want 000", {busy, done, error}); end
        checks++; if (muestras_out !== '0) begin errors++; $display("FAIL reset_count: got %0d want 0", muestras_out); end
        checks++; if (avg_ptos_x_ciclo !== 16'd0 || avg_frames !== 16'd0) begin errors++; $display("FAIL reset_cfg: got %0d/%0d want 0/0", avg_ptos_x_ciclo, avg_frames); end
        reset = 1'b0;
        step();
        checks++; if (avg_rst_n !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL idle_after_reset: got rst_n=%b busy=%b want 1/0", avg_rst_n, busy); end
    endtask

    task automatic test_acquisition();
        int          viol;
        int          exp_cnt;
        bit          reached;
        logic [31:0] sent;
        do_start(16'd8, 16'd4, 16'd2);
        checks++; if (avg_rst_n !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL clear_first: got rst_n=%b busy=%b want 0/1", avg_rst_n, busy); end
        checks++; if (avg_ptos_x_ciclo !== 16'd8 || avg_frames !== 16'd4) begin errors++; $display("FAIL cfg_latch: got %0d/%0d want 8/4", avg_ptos_x_ciclo, avg_frames); end
        // Triggers offered during CLEAR must never be taken.
        data_in_valid = 1'b1; frame_sync = 1'b1; data_in = 32'hDEAD;
        viol = 0;
        for (int i = 0; i < BUF_TAM; i++) begin
            step();
            if (avg_rst_n !== 1'b1 || avg_enable !== 1'b0 || avg_data_valid !== 1'b0 || busy !== 1'b1) viol++;
        end
        checks++; if (viol !== 0) begin errors++; $display("FAIL clear_window: got %0d bad cycles want 0", viol); end
        step();
        checks++; if (avg_enable !== 1'b1 || avg_data_valid !== 1'b0) begin errors++; $display("FAIL arm_entry: got en=%b dv=%b want 1/0", avg_enable, avg_data_valid); end
        frame_sync = 1'b0;
        viol = 0;
        for (int k = 0; k < 3; k++) begin
            data_in = 32'd100 + 32'(k);
            step();
            if (avg_data_valid !== 1'b0) viol++;
        end
        checks++; if (viol !== 0) begin errors++; $display("FAIL pre_trigger_gate: got %0d forwarded want 0", viol); end
        frame_sync = 1'b1; data_in = 32'h1000;
        step();
        checks++; if (avg_data_valid !== 1'b1 || avg_data !== 32'h1000) begin errors++; $display("FAIL trigger_fwd: got %b/%0h want 1/1000", avg_data_valid, avg_data); end
        exp_cnt = 0; reached = 1'b0; viol = 0;
        for (int cyc = 0; cyc < 100 && !reached; cyc++) begin
            sent          = 32'h1000 + 32'((cyc + 1) / 8);
            data_in       = sent;
            frame_sync    = ((cyc + 1) % 8 == 0);
            avg_out_valid = (cyc % 2 == 1);
            step();
            if (avg_out_valid) exp_cnt++;
            if (exp_cnt == 16) reached = 1'b1;
            else if (avg_data_valid !== 1'b1 || avg_data !== sent || muestras_out !== CNT_W'(exp_cnt)
                     || done !== 1'b0 || busy !== 1'b1) viol++;
        end
        checks++; if (viol !== 0) begin errors++; $display("FAIL run_stream: got %0d bad cycles want 0", viol); end
        checks++; if (muestras_out !== 32'd16 || done !== 1'b1) begin errors++; $display("FAIL done_count: got cnt=%0d done=%b want 16/1", muestras_out, done); end
        checks++; if (avg_enable !== 1'b0 || busy !== 1'b0 || avg_data_valid !== 1'b0) begin errors++; $display("FAIL done_outputs: got en=%b busy=%b dv=%b want 0/0/0", avg_enable, busy, avg_data_valid); end
        viol = 0;
        avg_out_valid = 1'b1; data_in_valid = 1'b1; frame_sync = 1'b1;
        repeat (10) begin
            step();
            if (avg_data_valid !== 1'b0 || muestras_out !== 32'd16 || done !== 1'b1) viol++;
        end
        checks++; if (viol !== 0) begin errors++; $display("FAIL done_hold: got %0d bad cycles want 0", viol); end
        avg_out_valid = 1'b0; data_in_valid = 1'b0; frame_sync = 1'b0;
    endtask

    task automatic test_config_errors();
        logic [15:0] tm [4] = '{16'd0, 16'd2049, 16'd8, 16'd8};
        logic [15:0] tn [4] = '{16'd4, 16'd4,    16'd0, 16'd4};
        logic [15:0] tr [4] = '{16'd2, 16'd2,    16'd2, 16'd0};
        for (int i = 0; i < 4; i++) begin
            do_start(tm[i], tn[i], tr[i]);
            checks++; if (error !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL cfg_err_%0d: got err=%b busy=%b want 1/0", i, error, busy); end
            checks++; if (avg_enable !== 1'b0 || done !== 1'b0 || muestras_out !== '0) begin errors++; $display("FAIL cfg_err_idle_%0d: got en=%b done=%b cnt=%0d want 0/0/0", i, avg_enable, done, muestras_out); end
            checks++; if (avg_ptos_x_ciclo !== tm[i] || avg_rst_n !== 1'b1) begin errors++; $display("FAIL cfg_err_latch_%0d: got M=%0d rst_n=%b want %0d/1", i, avg_ptos_x_ciclo, avg_rst_n, tm[i]); end
        end
        cfg_ptos_x_ciclo = 16'd8; cfg_frames = 16'd4; cfg_bloques = 16'd2;
        start = 1'b1; abort = 1'b1;
        step();
        start = 1'b0; abort = 1'b0;
        checks++; if (busy !== 1'b0 || error !== 1'b1) begin errors++; $display("FAIL abort_beats_start: got busy=%b err=%b want 0/1", busy, error); end
        do_start(16'd2048, 16'd4, 16'd2);
        checks++; if (error !== 1'b0 || busy !== 1'b1 || avg_rst_n !== 1'b0) begin errors++; $display("FAIL max_m_ok: got err=%b busy=%b rst_n=%b want 0/1/0", error, busy, avg_rst_n); end
        abort = 1'b1; step(); abort = 1'b0;
        checks++; if (busy !== 1'b0 || avg_rst_n !== 1'b1) begin errors++; $display("FAIL abort_clear: got busy=%b rst_n=%b want 0/1", busy, avg_rst_n); end
        do_start(16'd8, 16'd4, 16'd2);
        checks++; if (error !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL valid_restart: got err=%b busy=%b want 0/1", error, busy); end
        abort = 1'b1; step(); abort = 1'b0;
    endtask

    task automatic test_abort();
        go_to_run(16'd8, 16'd4, 16'd2);
        data_in_valid = 1'b1;
        repeat (5) begin
            avg_out_valid = 1'b1; step();
            avg_out_valid = 1'b0; step();
        end
        checks++; if (muestras_out !== 32'd5 || busy !== 1'b1) begin errors++; $display("FAIL pre_abort: got cnt=%0d busy=%b want 5/1", muestras_out, busy); end
        abort = 1'b1; step(); abort = 1'b0;
        checks++; if ({busy, avg_enable, done, avg_data_valid} !== 4'b0000) begin errors++; $display("FAIL abort_outputs: got %b want 0000", {busy, avg_enable, done, avg_data_valid}); end
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL abort_error: got %b want 0", error); end
        data_in_valid = 1'b0;
        step();
        checks++; if (avg_rst_n !== 1'b1) begin errors++; $display("FAIL abort_idle_rst_n: got %b want 1", avg_rst_n); end
        do_start(16'd8, 16'd4, 16'd2);
        checks++; if (avg_rst_n !== 1'b0 || muestras_out !== '0) begin errors++; $display("FAIL restart_clear: got rst_n=%b cnt=%0d want 0/0", avg_rst_n, muestras_out); end
        step();
        checks++; if (avg_rst_n !== 1'b1 || busy !== 1'b1 || avg_enable !== 1'b0) begin errors++; $display("FAIL restart_clear2: got rst_n=%b busy=%b en=%b want 1/1/0", avg_rst_n, busy, avg_enable); end
        abort = 1'b1; step(); abort = 1'b0;
    endtask

    task automatic test_ignored_start();
        int n;
        do_start(16'd8, 16'd4, 16'd2);
        repeat (10) step();
        cfg_ptos_x_ciclo = 16'd16; cfg_frames = 16'd9; cfg_bloques = 16'd5;
        start = 1'b1; step(); start = 1'b0;
        checks++; if (avg_ptos_x_ciclo !== 16'd8 || avg_frames !== 16'd4 || avg_rst_n !== 1'b1) begin errors++; $display("FAIL start_in_clear: got M=%0d N=%0d rst_n=%b want 8/4/1", avg_ptos_x_ciclo, avg_frames, avg_rst_n); end
        repeat (BUF_TAM - 11) step();
        checks++; if (avg_enable !== 1'b0) begin errors++; $display("FAIL clear_len_early: got en=%b want 0", avg_enable); end
        step();
        checks++; if (avg_enable !== 1'b1) begin errors++; $display("FAIL clear_len_arm: got en=%b want 1", avg_enable); end
        data_in_valid = 1'b1; frame_sync = 1'b1; data_in = 32'h2000;
        step();
        frame_sync = 1'b0;
        repeat (3) begin
            avg_out_valid = 1'b1; step();
            avg_out_valid = 1'b0; step();
        end
        start = 1'b1; step(); start = 1'b0;
        checks++; if (muestras_out !== 32'd3 || busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL start_in_run: got cnt=%0d busy=%b done=%b want 3/1/0", muestras_out, busy, done); end
        checks++; if (avg_ptos_x_ciclo !== 16'd8 || avg_frames !== 16'd4) begin errors++; $display("FAIL cfg_hold_run: got %0d/%0d want 8/4", avg_ptos_x_ciclo, avg_frames); end
        n = 3;
        avg_out_valid = 1'b1;
        while (done !== 1'b1 && n < 60) begin
            step();
            n++;
        end
        avg_out_valid = 1'b0; data_in_valid = 1'b0;
        checks++; if (done !== 1'b1 || n !== 16 || muestras_out !== 32'd16) begin errors++; $display("FAIL target_kept: got done=%b pulses=%0d cnt=%0d want 1/16/16", done, n, muestras_out); end
    endtask

    task automatic test_no_timeout();
        go_to_run(16'd8, 16'd4, 16'd2);
        repeat (2) begin
            avg_out_valid = 1'b1; step();
            avg_out_valid = 1'b0; step();
        end
        data_in_valid = 1'b0;
        repeat (150) step();
        checks++; if (busy !== 1'b1 || error !== 1'b0 || avg_enable !== 1'b1) begin errors++; $display("FAIL stall_wait: got busy=%b err=%b en=%b want 1/0/1", busy, error, avg_enable); end
        reset = 1'b1; step();
        checks++; if ({avg_rst_n, avg_enable, busy} !== 3'b000 || muestras_out !== '0) begin errors++; $display("FAIL mid_reset: got %b cnt=%0d want 000/0", {avg_rst_n, avg_enable, busy}, muestras_out); end
        checks++; if (avg_ptos_x_ciclo !== 16'd0 || avg_data !== 32'd0) begin errors++; $display("FAIL mid_reset_data: got M=%0d data=%0h want 0/0", avg_ptos_x_ciclo, avg_data); end
        reset = 1'b0; step();
    endtask

    initial begin
        test_reset();
        test_acquisition();
        test_config_errors();
        test_abort();
        test_ignored_start();
        test_no_timeout();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL time_limit: simulation did not finish within 2 ms");
        $fatal(1, "time limit");
    end

endmodule

// File: doc/prom_coherente_ctrl.md
Name: prom_coherente_ctrl

Overview:
Sequencer for the coherent-averaging datapath: latches M/N configuration, resets and clears the averager buffer, aligns the first input sample to a frame trigger, gates the input stream, counts averaged output samples and reports completion. Sits between the ADC/stream source plus CSR block and the averager; the averager's reset is active-low, enable-gated and needs BUF_TAM enable-low cycles to clear its buffer.

Parameters:
BUF_TAM, 2048, averager buffer depth; sets CLEAR duration and the maximum legal M.
CNT_W, 32, width of the output-sample counter.
TIMEOUT_CYCLES, 65536, watchdog limit; used only with the optional feature.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse; starts an acquisition from IDLE or DONE
abort  in  1  returns to IDLE from any state
cfg_ptos_x_ciclo  in  16  M, points per cycle
cfg_frames  in  16  N, frames averaged per output block
cfg_bloques  in  16  R, number of averaged blocks to collect
frame_sync  in  1  frame trigger, qualified by data_in_valid
data_in_valid  in  1  source stream valid
data_in  in  32  source stream data, signed
avg_rst_n  out  1  averager reset, active-low
avg_enable  out  1  averager enable
avg_ptos_x_ciclo  out  16  latched M
avg_frames  out  16  latched N
avg_data_valid  out  1  gated stream valid to averager
avg_data  out  32  registered stream data to averager
avg_out_valid  in  1  averager data_out_valid
busy  out  1  high in CLEAR, ARM and RUN
done  out  1  high in DONE
error  out  1  sticky config/timeout error; cleared by the next start or by reset
muestras_out  out  CNT_W  averaged samples counted so far

Behaviour:
- Reset values: avg_rst_n=0, avg_enable=0, avg_data_valid=0, avg_data=0, busy=0, done=0, error=0, muestras_out=0, latched config=0, state=IDLE.
- States: IDLE, CLEAR, ARM, RUN, DONE.
- IDLE: avg_rst_n=1, avg_enable=0.
- On start in IDLE or DONE:
  - Latch M, N, R and clear done, error and the counter.
  - If M==0, M>BUF_TAM, N==0 or R==0: set error=1 and stay in or go to IDLE.
  - Otherwise go to CLEAR.
- start in CLEAR/ARM/RUN is ignored.
- CLEAR:
  - First cycle: avg_rst_n=0.
  - Next BUF_TAM cycles: avg_rst_n=1, avg_enable=0, so the averager zeroes the whole buffer.
  - Then go to ARM. Total CLEAR length is BUF_TAM+1 cycles.
- ARM:
  - avg_enable=1, avg_data_valid=0.
  - The first cycle with data_in_valid&&frame_sync moves to RUN, and that same sample is forwarded as point 0.
- RUN:
  - avg_data_valid and avg_data are data_in_valid and data_in registered by 1 cycle.
  - frame_sync is ignored in RUN.
  - Each avg_out_valid increments muestras_out.
  - When the increment reaches M*R (full-width product in CNT_W bits), go to DONE on the following cycle and suppress further forwarding.
- DONE: avg_enable=0, avg_data_valid=0, done=1 held, muestras_out held.
- abort: next cycle state=IDLE; avg_enable, avg_data_valid, busy and done go to 0; error is unchanged. abort wins over start in the same cycle.
- reset mid-operation: all outputs return to reset values on the next edge, and avg_rst_n is asserted.
- avg_out_valid outside RUN is ignored; it is not counted.
- Latency:
  - First forwarded sample reaches the averager 1 cycle after the trigger sample.
  - First averaged output arrives after N full frames plus the averager pipeline.

Optional Feature:
PROM_CTRL_TIMEOUT_EN.
- Defined:
  - A counter runs in ARM and RUN; it is cleared by any data_in_valid.
  - If it reaches TIMEOUT_CYCLES, set error=1 and go to IDLE with avg_enable=0.
- Undefined: no watchdog; ARM and RUN wait indefinitely and error comes only from the config check.

Test Plan:
- Config M=8, N=4, R=2; start; continuous valid, data=frame index. Trigger on sample 0 must not occur before CLEAR (2049 cycles) ends; then muestras_out reaches exactly 16, done=1, avg_enable=0, and no avg_data_valid after DONE.
- Trigger check with M=8, N=4, R=2: valid samples before frame_sync are not forwarded; sample with frame_sync=1 appears as the first avg_data_valid exactly 1 cycle later.
- Start with M=0, then with M=2049, then with N=0: error=1, state stays IDLE, avg_enable=0, busy=0; a following valid start with M=8 clears error.
- abort asserted mid-RUN after 5 outputs: next cycle busy=0, avg_enable=0, done=0. A fresh start must pass through CLEAR again, with avg_rst_n low for 1 cycle.
- start pulses during CLEAR and RUN are ignored: counter and latched config are unchanged; changing cfg_* inputs mid-run does not change avg_ptos_x_ciclo or avg_frames.
- With PROM_CTRL_TIMEOUT_EN and TIMEOUT_CYCLES=100: stop data_in_valid in RUN; after 100 cycles error=1 and state is IDLE. Without the macro the block stays busy=1.
